addsub_arbiter: RTL and testbench

Round-robin scheduler that shares one 8-bit add/subtract datapath between NUM_REQ requesters. Accepts one operation at a time over per-requester valid/ready, computes a 9-bit registered result, and returns it on a single response channel tagged with the requester index. Sits between client blocks and the add/sub unit, replacing per-client adders.

---
 rtl/addsub_pkg.sv | 14 +
 rtl/addsub_unit.sv | 21 ++
 rtl/addsub_arbiter.sv | 167 ++++++++++++++++
 tb/tb_addsub_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared types and constants for the round-robin add/sub arbiter.
package addsub_pkg;

  localparam logic OP_ADD  = 1'b0;
  localparam logic OP_SUB  = 1'b1;
  localparam int   OPCNT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

endpackage

// File: rtl/addsub_unit.sv
// Combinational DATA_W add/subtract with a DATA_W+1 result; the top bit is carry (add) or borrow (sub).
module addsub_unit
  import addsub_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              op,
  output logic [DATA_W:0]   result
);

  always_comb begin
    if (op == OP_SUB) begin
      result = {1'b0, a} - {1'b0, b};
    end else begin
      result = {1'b0, a} + {1'b0, b};
    end
  end

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin scheduler sharing one add/sub unit between NUM_REQ requesters.
// Optional ADDSUB_ARB_OPCNT_EN adds a saturating response counter on op_count.
module addsub_arbiter
  import addsub_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ-1:0]         req_op,
  input  logic [NUM_REQ*DATA_W-1:0]  req_a,
  input  logic [NUM_REQ*DATA_W-1:0]  req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_W:0]            rsp_data,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic                       busy
`ifdef ADDSUB_ARB_OPCNT_EN
  ,
  output logic [OPCNT_W-1:0]         op_count
`endif
);

  localparam int IDW = $clog2(NUM_REQ);

  state_t            state_reg, state_next;
  logic [IDW-1:0]    rr_ptr_reg, rr_ptr_next;
  logic [IDW-1:0]    id_reg, id_next;
  logic [DATA_W-1:0] a_reg, a_next;
  logic [DATA_W-1:0] b_reg, b_next;
  logic              op_reg, op_next;
  logic [DATA_W:0]   rsp_data_reg, rsp_data_next;
  logic              rsp_valid_reg, rsp_valid_next;
  logic              busy_reg, busy_next;

  logic [DATA_W-1:0] a_arr [NUM_REQ];
  logic [DATA_W-1:0] b_arr [NUM_REQ];
  logic [IDW-1:0]    grant_idx;
  logic              grant_en;
  logic              rsp_hs;
  logic [DATA_W:0]   unit_result;

  // First valid index at or after ptr, wrapping around.
  function automatic logic [IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                             input logic [IDW-1:0]     ptr);
    logic [IDW-1:0] pick;
    logic           found;
    int             idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!found && valid[idx[IDW-1:0]]) begin
        pick  = idx[IDW-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign a_arr[gi]     = req_a[gi*DATA_W +: DATA_W];
      assign b_arr[gi]     = req_b[gi*DATA_W +: DATA_W];
      assign req_ready[gi] = grant_en && (grant_idx == IDW'(gi));
    end
  endgenerate

  assign grant_idx = rr_pick(req_valid, rr_ptr_reg);
  assign grant_en  = (state_reg == IDLE) && (|req_valid);
  assign rsp_hs    = (state_reg == RESP) && rsp_ready;

  addsub_unit #(
    .DATA_W(DATA_W)
  ) u_unit (
    .a      (a_reg),
    .b      (b_reg),
    .op     (op_reg),
    .result (unit_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= '0;
      id_reg        <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      op_reg        <= OP_ADD;
      rsp_data_reg  <= '0;
      rsp_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      rr_ptr_reg    <= rr_ptr_next;
      id_reg        <= id_next;
      a_reg         <= a_next;
      b_reg         <= b_next;
      op_reg        <= op_next;
      rsp_data_reg  <= rsp_data_next;
      rsp_valid_reg <= rsp_valid_next;
      busy_reg      <= busy_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    rr_ptr_next    = rr_ptr_reg;
    id_next        = id_reg;
    a_next         = a_reg;
    b_next         = b_reg;
    op_next        = op_reg;
    rsp_data_next  = rsp_data_reg;
    rsp_valid_next = rsp_valid_reg;
    busy_next      = busy_reg;
    case (state_reg)
      IDLE: begin
        if (grant_en) begin
          a_next     = a_arr[grant_idx];
          b_next     = b_arr[grant_idx];
          op_next    = req_op[grant_idx];
          id_next    = grant_idx;
          busy_next  = 1'b1;
          state_next = EXEC;
        end
      end
      EXEC: begin
        rsp_data_next  = unit_result;
        rsp_valid_next = 1'b1;
        state_next     = RESP;
      end
      RESP: begin
        if (rsp_hs) begin
          rsp_valid_next = 1'b0;
          busy_next      = 1'b0;
          rr_ptr_next    = (id_reg == IDW'(NUM_REQ - 1)) ? '0 : id_reg + 1'b1;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_id    = id_reg;
  assign busy      = busy_reg;

`ifdef ADDSUB_ARB_OPCNT_EN
  logic [OPCNT_W-1:0] op_count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_reg <= '0;
    end else if (rsp_hs && (op_count_reg != '1)) begin
      op_count_reg <= op_count_reg + 1'b1;
    end
  end

  assign op_count = op_count_reg;
`endif

endmodule

// File: tb/tb_addsub_arbiter.sv
// Self-checking bench for addsub_arbiter: vector table, directed corner cases, randomized run vs. reference model.
module tb_addsub_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   req_op;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [W:0]     rsp_data;
  logic [1:0]     rsp_id;
  logic           busy;
`ifdef ADDSUB_ARB_OPCNT_EN
  logic [15:0]    op_count;
`endif

  addsub_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
`ifdef ADDSUB_ARB_OPCNT_EN
    ,
    .op_count  (op_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  logic [W-1:0] a_v [N];
  logic [W-1:0] b_v [N];

  typedef struct {
    int         id;
    bit         op;
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_bus();
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = a_v[i];
      req_b[i*W +: W] = b_v[i];
    end
  endtask

  // Reference result from plain arithmetic, wrapped into 9 bits.
  function automatic logic [8:0] ref_calc(input bit op, input int a, input int b);
    int r;
    r = op ? (a - b) : (a + b);
    if (r < 0) r += 512;
    return 9'(r);
  endfunction

  task automatic do_reset();
    req_valid = '0;
    rsp_ready = 1'b1;
    rst_n     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Stop issuing and let any in-flight op finish, bounded.
  task automatic drain();
    bit done;
    done      = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 10 && !done; k++) begin
      #1;
      if (!busy && !rsp_valid) done = 1'b1;
      else @(negedge clk);
    end
    check("drain_idle", 32'(done), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    int          rsp_ids [$];
    int          rsp_cyc [$];
    logic [8:0]  rsp_dat [$];
    int          exp_ptr, g_cyc, e_id, w, clr, n_hs;
    bit          outst, hs;
    logic [8:0]  e_data;
    logic [N-1:0] exp_rdy;

    vecs[0] = '{0, 1'b0, 8'hFF, 8'h01, 9'h100};
    vecs[1] = '{2, 1'b1, 8'h03, 8'h05, 9'h1FE};
    vecs[2] = '{2, 1'b1, 8'h80, 8'h01, 9'h07F};
    vecs[3] = '{1, 1'b0, 8'h00, 8'h00, 9'h000};
    vecs[4] = '{3, 1'b1, 8'h00, 8'hFF, 9'h101};
    vecs[5] = '{3, 1'b0, 8'hFF, 8'hFF, 9'h1FE};
    vecs[6] = '{1, 1'b1, 8'h55, 8'h55, 9'h000};

    rst_n     = 1'b0;
    req_valid = '0;
    req_op    = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      a_v[i] = '0;
      b_v[i] = '0;
    end
    drive_bus();

    // Reset values
    @(negedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data",  32'(rsp_data),  32'd0);
    check("rst_rsp_id",    32'(rsp_id),    32'd0);
    check("rst_busy",      32'(busy),      32'd0);
`ifdef ADDSUB_ARB_OPCNT_EN
    check("rst_op_count",  32'(op_count),  32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);

    // Vector table: single requester, latency and arithmetic
    for (int v = 0; v < 7; v++) begin
      a_v[vecs[v].id]    = vecs[v].a;
      b_v[vecs[v].id]    = vecs[v].b;
      req_op[vecs[v].id] = vecs[v].op;
      drive_bus();
      req_valid = N'(1 << vecs[v].id);
      #1;
      check("vec_grant", 32'(req_ready), 32'(1 << vecs[v].id));
      @(negedge clk);
      req_valid = '0;
      #1;
      check("vec_t1_valid", 32'(rsp_valid), 32'd0);
      check("vec_t1_busy",  32'(busy),      32'd1);
      @(negedge clk);
      #1;
      check("vec_t2_valid", 32'(rsp_valid), 32'd1);
      check("vec_data",     32'(rsp_data),  32'(vecs[v].exp));
      check("vec_id",       32'(rsp_id),    32'(vecs[v].id));
      $display("vec %0d: id=%0d op=%0d a=%02h b=%02h -> data=%03h", v, vecs[v].id, vecs[v].op,
               vecs[v].a, vecs[v].b, rsp_data);
      @(negedge clk);
      #1;
      check("vec_t3_valid", 32'(rsp_valid), 32'd0);
      check("vec_t3_busy",  32'(busy),      32'd0);
      @(negedge clk);
    end

    // Fairness: all requesters valid, rsp_ready high
    do_reset();
    for (int i = 0; i < N; i++) begin
      a_v[i] = 8'(i);
      b_v[i] = 8'h01;
    end
    req_op = '0;
    drive_bus();
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      #1;
      if (rsp_valid) begin
        rsp_ids.push_back(int'(rsp_id));
        rsp_cyc.push_back(c);
        rsp_dat.push_back(rsp_data);
        $display("fair: cycle %0d id=%0d data=%03h", c, rsp_id, rsp_data);
      end
      @(negedge clk);
    end
    check("fair_count", 32'(rsp_ids.size()), 32'd5);
    for (int k = 0; k < 5 && k < rsp_ids.size(); k++) begin
      check("fair_order", 32'(rsp_ids[k]), 32'(k % N));
      check("fair_data",  32'(rsp_dat[k]), 32'((k % N) + 1));
      if (k > 0) check("fair_spacing", 32'(rsp_cyc[k] - rsp_cyc[k-1]), 32'd3);
    end
`ifdef ADDSUB_ARB_OPCNT_EN
    check("fair_op_count", 32'(op_count), 32'd5);
`endif
    drain();

    // Backpressure: req 1 sub 10-20, rsp_ready low for 5 cycles while others request
    a_v[1]    = 8'h10;
    b_v[1]    = 8'h20;
    req_op[1] = 1'b1;
    drive_bus();
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    #1;
    check("bp_grant", 32'(req_ready), 32'b0010);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    req_valid = 4'b1101;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_data",  32'(rsp_data),  32'h1F0);
      check("bp_id",    32'(rsp_id),    32'd1);
      check("bp_noready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_hs_valid", 32'(rsp_valid), 32'd1);
    $display("bp: id=%0d data=%03h accepted", rsp_id, rsp_data);
    @(negedge clk);
    #1;
    check("bp_after_valid", 32'(rsp_valid), 32'd0);
    check("bp_next_grant",  32'(req_ready), 32'b0100);
    @(negedge clk);

    // Reset during EXEC: outputs clear at once, no response, pointer back to 0
    req_valid = '0;
    #1;
    check("mid_in_exec", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rsp_data",  32'(rsp_data),  32'd0);
    check("mid_rsp_id",    32'(rsp_id),    32'd0);
    check("mid_busy",      32'(busy),      32'd0);
    check("mid_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("mid_no_rsp",  32'(rsp_valid), 32'd0);
      check("mid_no_busy", 32'(busy),      32'd0);
      @(negedge clk);
    end
    req_valid = 4'b1100;
    #1;
    check("mid_lowest_grant", 32'(req_ready), 32'b0100);
    $display("reset mid-op: next grant=%b", req_ready);
    @(negedge clk);
    drain();

    // Randomized run against the reference model
    do_reset();
    exp_ptr = 0;
    outst   = 1'b0;
    g_cyc   = 0;
    e_id    = 0;
    e_data  = '0;
    clr     = -1;
    n_hs    = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (clr >= 0) req_valid[clr] = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && i != clr && $urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          req_op[i]    = 1'($urandom_range(0, 1));
          a_v[i]       = 8'($urandom);
          b_v[i]       = 8'($urandom);
        end else if (req_valid[i] && $urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      drive_bus();
      rsp_ready = ($urandom_range(0, 3) != 0);
      clr = -1;
      #1;
      w       = -1;
      exp_rdy = '0;
      if (!outst) begin
        for (int k = 0; k < N; k++) begin
          if (w < 0 && req_valid[(exp_ptr + k) % N]) w = (exp_ptr + k) % N;
        end
        if (w >= 0) exp_rdy = N'(1 << w);
      end
      check("rnd_req_ready", 32'(req_ready), 32'(exp_rdy));
      check("rnd_busy",      32'(busy),      32'(outst && cyc > g_cyc));
      check("rnd_rsp_valid", 32'(rsp_valid), 32'(outst && cyc >= g_cyc + 2));
`ifdef ADDSUB_ARB_OPCNT_EN
      check("rnd_op_count",  32'(op_count),  32'(n_hs));
`endif
      hs = outst && (cyc >= g_cyc + 2) && rsp_ready;
      if (outst && cyc >= g_cyc + 2 && rsp_valid) begin
        check("rnd_rsp_data", 32'(rsp_data), 32'(e_data));
        check("rnd_rsp_id",   32'(rsp_id),   32'(e_id));
      end
      if (hs) begin
        $display("rnd: cycle %0d id=%0d data=%03h", cyc, rsp_id, rsp_data);
        outst   = 1'b0;
        exp_ptr = (e_id + 1) % N;
        n_hs++;
      end
      if (w >= 0) begin
        outst  = 1'b1;
        g_cyc  = cyc;
        e_id   = w;
        e_data = ref_calc(req_op[w], int'(a_v[w]), int'(b_v[w]));
        clr    = w;
      end
      @(negedge clk);
    end
    check("rnd_handshakes_seen", 32'(n_hs > 20), 32'd1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
